// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: services one load/store at a time
// against a word-addressed SRAM with a fixed latency, stalling the pipeline meanwhile.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        valid_o,
  output logic        err_o
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic        wr_q, wr_d, err_q, err_d;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic        req, commit, c_wr, c_fault;
  logic [31:0] c_addr, c_wdata;

  assign req = MemRead_i | MemWrite_i;

  // With LATENCY=1 the access commits on the capture edge, so use live inputs
  assign c_addr  = (state_q == IDLE) ? addr_i     : addr_q;
  assign c_wdata = (state_q == IDLE) ? wdata_i    : wdata_q;
  assign c_wr    = (state_q == IDLE) ? MemWrite_i : wr_q;
  assign c_fault = (c_addr[1:0] != 2'b00) |
                   ({2'b00, c_addr[31:2]} >= 32'(DEPTH_WORDS));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = addr_i;
          wdata_d = wdata_i;
          wr_d    = MemWrite_i;
          cnt_d   = 4'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_d = DONE;
            commit  = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_d == 4'd0) begin
          state_d = DONE;
          commit  = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (commit) begin
      err_d = c_fault;
      if (!c_fault && !c_wr) rdata_d = mem_q[c_addr[AW+1:2]];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Array is not reset; a reset on the commit edge drops the write
  always_ff @(posedge clk_i) begin
    if (!rst_i && commit && c_wr && !c_fault) mem_q[c_addr[AW+1:2]] <= c_wdata;
  end

  assign stall_o = !rst_i & (((state_q == IDLE) & req) | (state_q == BUSY));
  assign valid_o = (state_q == DONE);
  assign err_o   = (state_q == DONE) & err_q;
  assign rdata_o = rdata_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (LATENCY 2 and 1) checked each cycle
// against a per-access timeline model, plus literal spot checks.
module tb_dmem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2];
  logic        rd [2], wr [2];
  logic [31:0] ad [2], wd [2];
  logic        stall [2], vld [2], err [2];
  logic [31:0] rdat [2];

  logic        e_stall [2], e_vld [2], e_err [2];
  logic [31:0] e_rdata [2];
  logic [31:0] mdl [2][256];
  bit          chk_en = 1'b0;

  int n_cmp = 0, n_bad = 0, cyc = 0;
  int vcnt [2], ecnt [2];
  int vtimes [$];
  int t0, tdum;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_l2 (
    .clk_i(clk), .rst_i(rst[0]), .MemRead_i(rd[0]), .MemWrite_i(wr[0]),
    .addr_i(ad[0]), .wdata_i(wd[0]), .stall_o(stall[0]), .rdata_o(rdat[0]),
    .valid_o(vld[0]), .err_o(err[0]));

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_l1 (
    .clk_i(clk), .rst_i(rst[1]), .MemRead_i(rd[1]), .MemWrite_i(wr[1]),
    .addr_i(ad[1]), .wdata_i(wd[1]), .stall_o(stall[1]), .rdata_o(rdat[1]),
    .valid_o(vld[1]), .err_o(err[1]));

  function automatic int lat(int d);
    return (d == 0) ? 2 : 1;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("stall%0d", d), 32'(stall[d]), 32'(e_stall[d]));
        chk($sformatf("valid%0d", d), 32'(vld[d]),   32'(e_vld[d]));
        chk($sformatf("err%0d", d),   32'(err[d]),   32'(e_err[d]));
        chk($sformatf("rdata%0d", d), rdat[d],       e_rdata[d]);
        if (vld[d] === 1'b1) vcnt[d]++;
        if (err[d] === 1'b1) ecnt[d]++;
      end
      if (vld[1] === 1'b1) vtimes.push_back(cyc);
    end
  end

  // One access: request held from its first cycle through completion
  task automatic access(int d, logic r, logic w, logic [31:0] a, logic [31:0] dat,
                        output int tstart);
    bit f;
    int L;
    f = (a[1:0] != 2'b00) || (a[31:2] >= 256);
    L = lat(d);
    tstart = 0;
    for (int k = 0; k <= L; k++) begin
      @(posedge clk); #1;
      if (k == 0) tstart = cyc;
      rd[d] = r; wr[d] = w; ad[d] = a; wd[d] = dat;
      e_stall[d] = (k < L);
      e_vld[d]   = (k == L);
      e_err[d]   = (k == L) && f;
      if (k == L && !f) begin
        if (w) mdl[d][a[9:2]] = dat;
        else if (r) e_rdata[d] = mdl[d][a[9:2]];
      end
    end
  endtask

  task automatic idle(int d, int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      rd[d] = 1'b0; wr[d] = 1'b0; ad[d] = 32'd0; wd[d] = 32'd0;
      e_stall[d] = 1'b0; e_vld[d] = 1'b0; e_err[d] = 1'b0;
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; rd[d] = 1'b0; wr[d] = 1'b0; ad[d] = 32'd0; wd[d] = 32'd0;
      e_stall[d] = 1'b0; e_vld[d] = 1'b0; e_err[d] = 1'b0; e_rdata[d] = 32'd0;
      vcnt[d] = 0; ecnt[d] = 0;
    end
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    idle(0, 2);

    // LATENCY=2 instance
    access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, tdum);
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, tdum);
    chk("lit_load10", rdat[0], 32'hDEADBEEF);
    idle(0, 1);
    access(0, 1'b0, 1'b1, 32'h4, 32'h1234, tdum);
    access(0, 1'b1, 1'b0, 32'h4, 32'h0, tdum);
    access(0, 1'b1, 1'b0, 32'h13, 32'h0, tdum);
    chk("lit_misalign_err", 32'(err[0]), 32'd1);
    chk("lit_misalign_hold", rdat[0], 32'h1234);
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, tdum);
    chk("lit_reload10", rdat[0], 32'hDEADBEEF);
    idle(0, 2);
    access(0, 1'b0, 1'b1, 32'h0, 32'h0C0FFEE0, tdum);
    access(0, 1'b0, 1'b1, 32'h400, 32'h00000BAD, tdum);
    chk("lit_oor_err", 32'(err[0]), 32'd1);
    access(0, 1'b1, 1'b0, 32'h0, 32'h0, tdum);
    chk("lit_load0", rdat[0], 32'h0C0FFEE0);
    access(0, 1'b1, 1'b1, 32'h20, 32'hA5A5A5A5, tdum);
    chk("lit_both_hold", rdat[0], 32'h0C0FFEE0);
    access(0, 1'b1, 1'b0, 32'h20, 32'h0, tdum);
    chk("lit_load20", rdat[0], 32'hA5A5A5A5);
    access(0, 1'b0, 1'b1, 32'h30, 32'h22222222, tdum);
    idle(0, 1);

    // Store interrupted by reset in its second cycle
    @(posedge clk); #1;
    wr[0] = 1'b1; ad[0] = 32'h30; wd[0] = 32'h11111111;
    e_stall[0] = 1'b1; e_vld[0] = 1'b0; e_err[0] = 1'b0;
    @(posedge clk); #1;
    rst[0] = 1'b1; e_stall[0] = 1'b0;
    @(posedge clk); #1;
    rst[0] = 1'b0; wr[0] = 1'b0; ad[0] = 32'd0; wd[0] = 32'd0;
    e_rdata[0] = 32'd0;
    chk("lit_rst_stall", 32'(stall[0]), 32'd0);
    idle(0, 2);
    access(0, 1'b1, 1'b0, 32'h30, 32'h0, tdum);
    chk("lit_load30", rdat[0], 32'h22222222);
    idle(0, 2);
    chk("lit_vcnt0", 32'(vcnt[0]), 32'd13);
    chk("lit_ecnt0", 32'(ecnt[0]), 32'd2);

    // LATENCY=1 instance: preload, then three back-to-back loads
    access(1, 1'b0, 1'b1, 32'h10, 32'h55, tdum);
    access(1, 1'b0, 1'b1, 32'h14, 32'h66, tdum);
    access(1, 1'b0, 1'b1, 32'h18, 32'h77, tdum);
    idle(1, 1);
    vtimes.delete();
    access(1, 1'b1, 1'b0, 32'h10, 32'h0, t0);
    chk("lit_l1_a", rdat[1], 32'h55);
    access(1, 1'b1, 1'b0, 32'h14, 32'h0, tdum);
    chk("lit_l1_b", rdat[1], 32'h66);
    access(1, 1'b1, 1'b0, 32'h18, 32'h0, tdum);
    chk("lit_l1_c", rdat[1], 32'h77);
    idle(1, 3);
    chk("l1_vpulses", 32'(vtimes.size()), 32'd3);
    for (int i = 0; i < vtimes.size() && i < 3; i++)
      chk($sformatf("l1_vtime%0d", i), 32'(vtimes[i]), 32'(t0 + 1 + 2 * i));
    chk("lit_ecnt1", 32'(ecnt[1]), 32'd0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined RISC-V core: the slave end of the MEM-stage request bundle (MemRead, MemWrite, ALUResult as address, ALUinB as store data) issued out of the EX/MEM pipeline register. It services each load/store against an internal word-addressed SRAM with a fixed, parameterised access latency. While an access is in flight it asserts a stall that freezes the front of the pipeline. It returns load data and a completion pulse to the MEM/WB stage.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words in the array (power of two, ≥2)
- LATENCY, 2: cycles from request acceptance to completion (1..15)

- clk_i  in  1  clock; all state changes on rising edge
- rst_i  in  1  reset; synchronous, active-high
- MemRead_i  in  1  load request (from EX/MEM)
- MemWrite_i  in  1  store request (from EX/MEM)
- addr_i  in  32  byte address (ALUResult)
- wdata_i  in  32  store data (ALUinB)
- stall_o  out  1  hold EX/MEM and earlier stages this cycle
- rdata_o  out  32  load data; holds the last completed load value
- valid_o  out  1  one-cycle completion pulse
- err_o  out  1  one-cycle pulse with valid_o: misaligned or out-of-range access

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: req = MemRead_i | MemWrite_i. If req is set, capture addr, wdata, and op (write if MemWrite_i, else read) and load cnt = LATENCY-1. Then go to BUSY, or go directly to DONE if LATENCY = 1.
- BUSY: decrement cnt. When cnt = 0 at the edge, go to DONE. Inputs are ignored.
- Access commit happens on the edge entering DONE. A write updates mem[addr[w+1:2]]. A read loads rdata_o.
- DONE: valid_o = 1, and err_o = 1 if the access faulted. Always return to IDLE. Inputs are ignored; the pipeline advances at the end of this cycle.
- Both MemRead_i and MemWrite_i set: the request is treated as a write only. rdata_o is unchanged and err_o is not raised.
- Fault: addr_i[1:0] ≠ 0, or addr_i[31:2] ≥ DEPTH_WORDS. The request still runs the full latency, but there is no array access and rdata_o is unchanged. err_o pulses with valid_o.
- Width: word index = addr[$clog2(DEPTH_WORDS)+1:2]; the out-of-range check uses the full addr[31:2]. cnt width = 4.
- stall_o = !rst_i & ((IDLE & req) | BUSY). It is combinational and never asserted in DONE.

## Timing
- Reset values: state = IDLE, stall_o = 0, valid_o = 0, err_o = 0, rdata_o = 0, cnt = 0. Array contents are not reset.
- A request first seen in cycle T:
  - stall_o is high in cycles T..T+LATENCY-1.
  - valid_o is high in cycle T+LATENCY.
  - rdata_o is valid from T+LATENCY and holds until the next completed load.
- Back-to-back requests: the next request is presented at T+LATENCY+1 and accepted then. Throughput is one access per LATENCY+1 cycles.
- The same request still visible during DONE must not be re-captured.
- rst_i asserted in BUSY or DONE returns the FSM to IDLE at that edge. An uncommitted write is dropped and never performed. A write already committed (edge into DONE) is kept.
- rst_i asserted in cycle T with a request: stall_o = 0 in T, and nothing is captured.

## Test plan
- Store then load, LATENCY = 2: store 0xDEADBEEF to 0x10, then load 0x10. Expected: stall_o high 2 cycles per access, and valid_o high in the 3rd cycle of each. The load's rdata_o = 0xDEADBEEF.
- Misaligned load from 0x13 with rdata_o = 0x1234: err_o and valid_o pulse together at T+2, and rdata_o stays 0x1234. A following load from 0x10 returns the stored word.
- Out-of-range store to 0x400 with DEPTH_WORDS = 256: err_o pulses at completion. A load from 0x0 afterwards is unchanged.
- Both MemRead_i and MemWrite_i set, data 0xA5A5A5A5 to 0x20: the write happens and rdata_o is unchanged. A later load from 0x20 returns 0xA5A5A5A5.
- rst_i pulsed in cycle T+1 of a store (0x11111111 to 0x30) after 0x30 was preloaded with 0x22222222. Expected: stall_o = 0 at T+2, and valid_o never pulses for that store. A load from 0x30 returns 0x22222222.
- LATENCY = 1, three back-to-back loads: stall_o high exactly 1 cycle each, valid_o at T+1, T+3, T+5. No double capture in any DONE cycle.
